// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit seven-segment scan controller with blanking and frame-synchronous commit
module seg_scan_ctrl #(
    parameter int TICK_DIV  = 131072,
    parameter int BLANK_CYC = 1024,
    parameter int CNT_W     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_dp,
    input  logic [3:0] dig_en,
    input  logic       lzb,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [4:0]       shadow [4];
    logic [4:0]       disp   [4];
    logic             tick;
    logic             zero_hi;
    logic             suppress;
    logic [3:0]       an_d;
    logic [6:0]       seg_d;
    logic             dp_d;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign tick = (cnt == LAST_CNT);

    // Leading-zero test looks only at the digit in the slot and everything to its left.
    always_comb begin
        zero_hi = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (2'(i) >= idx && disp[i][3:0] != 4'h0) begin
                zero_hi = 1'b0;
            end
        end
        suppress = !dig_en[idx] || (lzb && idx != 2'd0 && zero_hi);
        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (cnt >= BLANK_END && !suppress) begin
            an_d  = ~(4'b0001 << idx);
            seg_d = hex7(disp[idx][3:0]);
            dp_d  = ~disp[idx][4];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            frame_done <= 1'b0;
            an         <= 4'hF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= 5'd0;
                disp[i]   <= 5'd0;
            end
        end else begin
            cnt        <= tick ? '0 : cnt + 1'b1;
            frame_done <= tick && idx == 2'd3;
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
            if (tick) begin
                idx <= idx + 2'd1;
            end
            // Commit samples shadow before this edge's write lands.
            if (tick && idx == 2'd3) begin
                for (int i = 0; i < 4; i++) begin
                    disp[i] <= shadow[i];
                end
            end
            if (wr_en) begin
                shadow[wr_addr] <= {wr_dp, wr_data};
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - randomized and directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

    localparam int TD = 8;
    localparam int BC = 2;
    localparam int FR = 4 * TD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [3:0] wr_data = 4'd0;
    logic       wr_dp = 1'b0;
    logic [3:0] dig_en = 4'hF;
    logic       lzb = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    int checks = 0;
    int failures = 0;

    int         t = 0;
    logic [4:0] m_sh   [4];
    logic [4:0] m_disp [4];
    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYC(BC), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_dp(wr_dp), .dig_en(dig_en), .lzb(lzb), .an(an), .seg(seg), .dp(dp),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] exp_out(input int tt);
        int  slot;
        bit  all_zero;
        slot = (tt / TD) % 4;
        if ((tt % TD) < BC) return 12'hFFF;
        all_zero = 1'b1;
        for (int j = slot; j < 4; j++) if (m_disp[j][3:0] != 4'h0) all_zero = 1'b0;
        if (!dig_en[slot] || (lzb && slot > 0 && all_zero)) return 12'hFFF;
        return {4'hF & ~(4'd1 << slot), hex_tab[m_disp[slot][3:0]], ~m_disp[slot][4]};
    endfunction

    task automatic step();
        logic [11:0] e;
        logic        efd;
        @(posedge clk);
        #1;
        if (!rst) begin
            e   = 12'hFFF;
            efd = 1'b0;
            t   = 0;
            for (int i = 0; i < 4; i++) begin
                m_sh[i]   = 5'd0;
                m_disp[i] = 5'd0;
            end
        end else begin
            e   = exp_out(t);
            efd = ((t % FR) == FR - 1);
            if (efd) for (int i = 0; i < 4; i++) m_disp[i] = m_sh[i];
            if (wr_en) m_sh[wr_addr] = {wr_dp, wr_data};
            t++;
        end
        checks++;
        assert ({an, seg, dp, frame_done} === {e, efd}) else begin
            failures++;
            $error("FAIL outs t=%0d got an=%h seg=%h dp=%b fd=%b exp an=%h seg=%h dp=%b fd=%b",
                   t, an, seg, dp, frame_done, e[11:8], e[7:1], e[0], efd);
        end
    endtask

    task automatic adv(input int m);
        do step(); while (((t - 1) % FR) != m);
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] ex);
        checks++;
        assert (obs === ex) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, obs, ex);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_sh[i]   = 5'd0;
            m_disp[i] = 5'd0;
        end
        #1 rst = 1'b0;
        #1 chk("reset_outs", {an, seg, dp}, 12'hFFF);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        adv(2);
        chk("first_anode", {an, seg, dp}, {4'hE, 7'h40, 1'b1});

        for (int i = 0; i < 800; i++) begin
            wr_en   = ($urandom % 3) == 0;
            wr_addr = 2'($urandom);
            wr_data = ($urandom % 2) ? 4'h0 : 4'($urandom);
            wr_dp   = ($urandom % 4) == 0;
            if (i % 64 == 0) begin
                dig_en = 4'($urandom);
                lzb    = 1'($urandom);
            end
            step();
        end
        wr_en  = 1'b0;
        dig_en = 4'hF;
        lzb    = 1'b0;

        adv(5);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'h1; wr_dp = 1'b0;
        step();
        wr_en = 1'b0;
        adv(30);
        wr_en = 1'b1; wr_data = 4'h8;
        step();
        wr_en = 1'b0;
        adv(2);
        chk("atomic_old", {an, seg}, {4'hE, 7'h79});
        adv(2);
        chk("atomic_new", {an, seg}, {4'hE, 7'h00});

        wr_en = 1'b1; wr_dp = 1'b0;
        wr_addr = 2'd3; wr_data = 4'h0; step();
        wr_addr = 2'd2; wr_data = 4'h0; step();
        wr_addr = 2'd1; wr_data = 4'h5; step();
        wr_addr = 2'd0; wr_data = 4'h0; step();
        wr_en = 1'b0;
        lzb   = 1'b1;
        adv(31);
        adv(3);
        chk("lzb_d0", {an, seg}, {4'hE, 7'h40});
        adv(11);
        chk("lzb_d1", {an, seg}, {4'hD, 7'h12});
        adv(19);
        chk("lzb_d2", {an, seg}, {4'hF, 7'h7F});
        adv(27);
        chk("lzb_d3", {an, seg}, {4'hF, 7'h7F});
        lzb = 1'b0;
        adv(19);
        chk("nolzb_d2", {an, seg}, {4'hB, 7'h40});

        dig_en = 4'b1011;
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h5; wr_dp = 1'b1;
        step();
        wr_en = 1'b0;
        adv(31);
        adv(9);
        chk("dp_blank", {an, dp}, {4'hF, 1'b1});
        adv(11);
        chk("dp_lit", {an, seg, dp}, {4'hD, 7'h12, 1'b0});
        adv(19);
        chk("mask_d2", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});

        adv(20);
        #2 rst = 1'b0;
        #1 chk("async_clear", {an, seg, dp, frame_done}, 13'h1FFE);
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        adv(2);
        chk("restart_slot0", {an, seg, dp}, {4'hE, 7'h40, 1'b1});
        for (int i = 0; i < 40; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
